// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - decode freeze generator tracking EXE/MEM destination writes
module hazard_scoreboard #(
   parameter int REG_ADDR_W  = 4,
   parameter int FORWARDING  = 0,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   id_valid,
   input  logic [REG_ADDR_W-1:0]  id_src1,
   input  logic [REG_ADDR_W-1:0]  id_src2,
   input  logic                   id_uses_src1,
   input  logic                   id_uses_src2,
   input  logic [REG_ADDR_W-1:0]  id_dst,
   input  logic                   id_wb_en,
   input  logic                   id_mem_read,
   input  logic                   branch_taken,
   output logic                   freeze,
   output logic [1:0]             hazard_cause,
   output logic [REG_ADDR_W-1:0]  exe_dst,
   output logic [REG_ADDR_W-1:0]  mem_dst,
   output logic                   exe_wb_en,
   output logic                   mem_wb_en,
   output logic                   exe_mem_read,
   output logic [STALL_CNT_W-1:0] stall_count
);

   // The all-ones address is the PC, which decode substitutes itself, so it never conflicts.
   localparam logic [REG_ADDR_W-1:0] PC_REG = '1;

   logic [REG_ADDR_W-1:0]  exe_dst_q, exe_dst_d;
   logic                   exe_wb_en_q, exe_wb_en_d;
   logic                   exe_mem_read_q, exe_mem_read_d;
   logic [REG_ADDR_W-1:0]  mem_dst_q, mem_dst_d;
   logic                   mem_wb_en_q, mem_wb_en_d;
   logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

   logic src1_exe, src2_exe, src1_mem, src2_mem;
   logic hazard;

   always_comb begin
      src1_exe = id_uses_src1 & exe_wb_en_q & (exe_dst_q == id_src1) & (id_src1 != PC_REG);
      src2_exe = id_uses_src2 & exe_wb_en_q & (exe_dst_q == id_src2) & (id_src2 != PC_REG);
      src1_mem = id_uses_src1 & mem_wb_en_q & (mem_dst_q == id_src1) & (id_src1 != PC_REG);
      src2_mem = id_uses_src2 & mem_wb_en_q & (mem_dst_q == id_src2) & (id_src2 != PC_REG);

      hazard_cause = {src1_mem | src2_mem, src1_exe | src2_exe};

      // With forwarding, only a load still in EXE cannot be bypassed in time.
      if (FORWARDING != 0) begin
         hazard = hazard_cause[0] & exe_mem_read_q;
      end else begin
         hazard = hazard_cause[0] | hazard_cause[1];
      end

      freeze = hazard & id_valid & ~branch_taken;
   end

   always_comb begin
      mem_dst_d      = exe_dst_q;
      mem_wb_en_d    = exe_wb_en_q;
      exe_dst_d      = '0;
      exe_wb_en_d    = 1'b0;
      exe_mem_read_d = 1'b0;
      if (!(freeze || branch_taken || !id_valid)) begin
         exe_dst_d      = id_dst;
         exe_wb_en_d    = id_wb_en;
         exe_mem_read_d = id_mem_read;
      end

      stall_count_d = stall_count_q;
      if (freeze && (stall_count_q != '1)) begin
         stall_count_d = stall_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         exe_dst_q      <= '0;
         exe_wb_en_q    <= 1'b0;
         exe_mem_read_q <= 1'b0;
         mem_dst_q      <= '0;
         mem_wb_en_q    <= 1'b0;
         stall_count_q  <= '0;
      end else begin
         exe_dst_q      <= exe_dst_d;
         exe_wb_en_q    <= exe_wb_en_d;
         exe_mem_read_q <= exe_mem_read_d;
         mem_dst_q      <= mem_dst_d;
         mem_wb_en_q    <= mem_wb_en_d;
         stall_count_q  <= stall_count_d;
      end
   end

   assign exe_dst      = exe_dst_q;
   assign exe_wb_en    = exe_wb_en_q;
   assign exe_mem_read = exe_mem_read_q;
   assign mem_dst      = mem_dst_q;
   assign mem_wb_en    = mem_wb_en_q;
   assign stall_count  = stall_count_q;

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Hazard scoreboard that produces the `freeze` signal consumed by the decode stage and the fetch stage. It is the producer side of the decode stage's freeze input. It shadows the destination and write-back state of the instructions in the EXE and MEM slots. It stalls decode whenever a source register of the instruction in ID depends on a write that is not yet visible. One instance sits beside the decode stage. Its inputs come from the decode stage's register-address outputs and control outputs, and from the branch-taken signal of the execute stage.

## Interface
- `REG_ADDR_W`, default 4: register address width.
- `FORWARDING`, default 0: 0 means no forwarding unit, so any pending write stalls. 1 means a forwarding unit is present, so only load-use stalls.
- `STALL_CNT_W`, default 16: width of the stall statistics counter.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `id_valid`, in, 1: ID holds a real instruction whose condition passed.
- `id_src1`, in, REG_ADDR_W: Rn address from decode.
- `id_src2`, in, REG_ADDR_W: second read address (Rm, or Rd for stores) from decode.
- `id_uses_src1`, in, 1: instruction reads Rn.
- `id_uses_src2`, in, 1: instruction reads the second operand; high for a register operand or a store.
- `id_dst`, in, REG_ADDR_W: destination address.
- `id_wb_en`, in, 1: instruction writes the register file.
- `id_mem_read`, in, 1: instruction is a load.
- `branch_taken`, in, 1: EXE resolved a taken branch this cycle.
- `freeze`, out, 1: stall IF and ID; combinational.
- `hazard_cause`, out, 2: bit0 = EXE-slot match, bit1 = MEM-slot match, before masking.
- `exe_dst`, `mem_dst`, out, REG_ADDR_W: shadow slot destinations.
- `exe_wb_en`, `mem_wb_en`, `exe_mem_read`, out, 1 each: shadow slot flags.
- `stall_count`, out, STALL_CNT_W: number of cycles with `freeze`=1; saturating.

## Operation
- Each shadow slot is {dst, wb_en, mem_read}. A bubble is all zeros.
- Match terms:
  - src1 matches slot S when `id_uses_src1` & S.wb_en & (S.dst == `id_src1`) & (`id_src1` != all-ones). The same rule applies to src2.
  - Register 15 (all-ones) never matches, because decode substitutes the PC for it.
- `hazard_cause[0]` = src1 or src2 matches EXE. `hazard_cause[1]` = src1 or src2 matches MEM.
- hazard:
  - With FORWARDING=0: `hazard_cause[0] | hazard_cause[1]`.
  - With FORWARDING=1: `hazard_cause[0] & exe_mem_read`. A MEM-slot match never stalls.
- `freeze` = hazard & `id_valid` & ~`branch_taken`. A taken branch flushes ID, so a flushed instruction is never stalled.
- Slot update on each rising edge:
  - MEM <= EXE.
  - EXE <= bubble if `freeze` | `branch_taken` | ~`id_valid`; otherwise EXE <= {`id_dst`, `id_wb_en`, `id_mem_read`}.
- A WB-stage slot is not tracked. The register file writes on the falling edge, so ID reads observe a WB write in the same cycle.
- `stall_count` increments when `freeze`=1. It holds at all-ones and never wraps.

## Timing
- Reset (`rst`=0, asynchronous, any time including mid-stall):
  - Both slots become bubbles immediately.
  - `stall_count` = 0.
  - `freeze` = 0 and `hazard_cause` = 0.
  - All shadow outputs are 0.
- `freeze` and `hazard_cause` are combinational from the current inputs and the registered slots. They are valid in the same cycle as the ID inputs, with zero latency.
- A dependent ALU instruction directly behind its producer, with FORWARDING=0:
  - It stalls for 2 cycles: the first for the EXE match, the second for the MEM match.
  - It issues on the third cycle.
  - If one intervening instruction separates them, it stalls for 1 cycle.
- With FORWARDING=1, a load-use dependency stalls for exactly 1 cycle. A non-load dependency stalls for 0 cycles.
- When `branch_taken` is high in the same cycle as a hazard:
  - `freeze` = 0.
  - EXE becomes a bubble on the next edge.
  - MEM still receives the old EXE contents.
- When both src1 and src2 match, or both slots match, the stall is one per cycle. It is not additive.

## Test plan
- Reset check: hold `rst`=0 during an active stall. Required: `freeze`, `hazard_cause`, all shadow outputs and `stall_count` read 0 asynchronously, before the next edge.
- FORWARDING=0, producer dst=1 with wb_en=1, then consumer with src1=1 and uses_src1=1:
  - `freeze` reads 1,1,0.
  - `hazard_cause` reads 01, 10, 00.
  - `stall_count` ends at 2.
- FORWARDING=1:
  - A load with dst=2 followed by a consumer with src2=2: `freeze` = 1 for one cycle.
  - The same sequence with mem_read=0: no freeze.
- Non-match cases, each required to give `freeze`=0 throughout:
  - src1 = 15 with a pending dst of 15.
  - uses_src2 = 0 with src2 matching.
  - id_valid = 0 with matching sources.
- Branch case: hazard pending and `branch_taken`=1. Required: `freeze`=0 that cycle, `exe_wb_en`=0 after the edge, and `mem_dst` equal to the prior `exe_dst`.
- Saturation: with STALL_CNT_W=4, force 20 consecutive stall cycles. Required: `stall_count` holds at 15.
